// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through data cache.
package dcache_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_e;

   localparam int LINE_WORDS = 4;
   localparam int OFF_W      = 2;              // word offset within a line
   localparam int BYTE_W     = 2;              // byte offset within a word
   localparam int LINE_LSB   = OFF_W + BYTE_W; // first index bit of the address

   // Index width for a cache of 'sets' lines (sets must be a power of two >= 2).
   function automatic int idx_width(input int sets);
      return $clog2(sets);
   endfunction

   // Tag width: everything above the index.
   function automatic int tag_width(input int width, input int sets);
      return width - idx_width(sets) - LINE_LSB;
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the data cache. Only the valid bits are reset;
// tag and data arrays are written at the clock edge and read combinationally.
module dcache_array
   import dcache_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int SETS  = 16,
   localparam int IDX_W = idx_width(SETS),
   localparam int TAG_W = tag_width(WIDTH, SETS)
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   // combinational read of one line
   input  logic [IDX_W-1:0]                   rd_idx_i,
   output logic                               rd_valid_o,
   output logic [TAG_W-1:0]                   rd_tag_o,
   output logic [LINE_WORDS-1:0][WIDTH-1:0]   rd_line_o,
   // single-word write (store hit or refill beat)
   input  logic                               wr_en_i,
   input  logic [IDX_W-1:0]                   wr_idx_i,
   input  logic [OFF_W-1:0]                   wr_off_i,
   input  logic [WIDTH-1:0]                   wr_data_i,
   // line completion: write tag and set valid
   input  logic                               fill_en_i,
   input  logic [IDX_W-1:0]                   fill_idx_i,
   input  logic [TAG_W-1:0]                   fill_tag_i
);

   logic [SETS-1:0]                   valid_q;
   logic [TAG_W-1:0]                  tag_q  [SETS];
   logic [LINE_WORDS-1:0][WIDTH-1:0]  data_q [SETS];

   // Valid bits: cleared by reset, set when a refill completes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= {SETS{1'b0}};
      end else if (fill_en_i) begin
         valid_q[fill_idx_i] <= 1'b1;
      end
   end

   // Tag array: written on refill completion, never reset.
   always_ff @(posedge clk_i) begin
      if (fill_en_i) begin
         tag_q[fill_idx_i] <= fill_tag_i;
      end
   end

   // Data array: one word per cycle from stores or refill beats, never reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         data_q[wr_idx_i][wr_off_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache. Load hits return
// data in the same cycle; load misses stall while a 4-word line is refilled
// from the memory's combinational read port, one word per cycle.
module dcache
   import dcache_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int SETS  = 16,
   parameter  int CNT_W = 32,
   localparam int IDX_W = idx_width(SETS),
   localparam int TAG_W = tag_width(WIDTH, SETS),
   localparam int LA_W  = WIDTH - LINE_LSB
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] WD,
   input  logic             RE,
   input  logic             WE,
   output logic [WIDTH-1:0] RD,
   output logic             STALL,
   output logic [WIDTH-1:0] MEM_A,
   output logic [WIDTH-1:0] MEM_WD,
   output logic             MEM_WE,
   input  logic [WIDTH-1:0] MEM_RD,
   output logic [CNT_W-1:0] HIT_CNT,
   output logic [CNT_W-1:0] MISS_CNT
);

   // Saturating increment for the performance counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   // Address split
   logic [IDX_W-1:0] idx_s;
   logic [TAG_W-1:0] tag_s;
   logic [OFF_W-1:0] off_s;
   logic             unused_byte_off_s;

   assign idx_s             = A[LINE_LSB +: IDX_W];
   assign tag_s             = A[WIDTH-1 -: TAG_W];
   assign off_s             = A[BYTE_W +: OFF_W];
   assign unused_byte_off_s = ^A[BYTE_W-1:0];   // loads/stores are word aligned

   // Control state
   state_e           state_q;
   logic [OFF_W-1:0] fcnt_q;
   logic [LA_W-1:0]  base_q;      // line address {tag, index} of the refill
   logic             replay_q;    // next load hit is the replay of a miss
   logic [CNT_W-1:0] hit_cnt_q;
   logic [CNT_W-1:0] miss_cnt_q;

   // Array interface
   logic                             arr_valid_s;
   logic [TAG_W-1:0]                 arr_tag_s;
   logic [LINE_WORDS-1:0][WIDTH-1:0] arr_line_s;
   logic                             wr_en_s;
   logic [IDX_W-1:0]                 wr_idx_s;
   logic [OFF_W-1:0]                 wr_off_s;
   logic [WIDTH-1:0]                 wr_data_s;
   logic                             fill_en_s;

   logic hit_s;
   logic load_s;
   logic fill_last_s;

   assign hit_s       = arr_valid_s && (arr_tag_s == tag_s);
   assign load_s      = RE && !WE;
   assign fill_last_s = (fcnt_q == {OFF_W{1'b1}});

   dcache_array #(
      .WIDTH (WIDTH),
      .SETS  (SETS)
   ) u_array (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .rd_idx_i   (idx_s),
      .rd_valid_o (arr_valid_s),
      .rd_tag_o   (arr_tag_s),
      .rd_line_o  (arr_line_s),
      .wr_en_i    (wr_en_s),
      .wr_idx_i   (wr_idx_s),
      .wr_off_i   (wr_off_s),
      .wr_data_i  (wr_data_s),
      .fill_en_i  (fill_en_s),
      .fill_idx_i (base_q[IDX_W-1:0]),
      .fill_tag_i (base_q[LA_W-1 -: TAG_W])
   );

   // Datapath muxing: CPU/memory outputs and array write port per state.
   always_comb begin
      RD        = {WIDTH{1'b0}};
      STALL     = 1'b0;
      MEM_A     = A;
      MEM_WD    = WD;
      MEM_WE    = WE;
      wr_en_s   = 1'b0;
      wr_idx_s  = idx_s;
      wr_off_s  = off_s;
      wr_data_s = WD;
      fill_en_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (WE) begin
               // write-through; keep cached copy coherent on a hit
               wr_en_s = hit_s;
            end else if (RE) begin
               if (hit_s) begin
                  RD = arr_line_s[off_s];
               end else begin
                  STALL = 1'b1;
               end
            end else begin
               RD = {WIDTH{1'b0}};
            end
         end
         FILL: begin
            STALL     = 1'b1;
            MEM_WE    = 1'b0;
            MEM_A     = {base_q, fcnt_q, {BYTE_W{1'b0}}};
            wr_en_s   = 1'b1;
            wr_idx_s  = base_q[IDX_W-1:0];
            wr_off_s  = fcnt_q;
            wr_data_s = MEM_RD;
            fill_en_s = fill_last_s;
         end
         default: begin
            STALL  = 1'b0;
            MEM_WE = 1'b0;
         end
      endcase
   end

   // Control FSM: miss detection, refill sequencing, replay flag and counters.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         fcnt_q     <= {OFF_W{1'b0}};
         base_q     <= {LA_W{1'b0}};
         replay_q   <= 1'b0;
         hit_cnt_q  <= {CNT_W{1'b0}};
         miss_cnt_q <= {CNT_W{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (load_s) begin
                  if (hit_s) begin
                     if (!replay_q) begin
                        hit_cnt_q <= sat_inc(hit_cnt_q);
                     end
                     replay_q <= 1'b0;
                  end else begin
                     miss_cnt_q <= sat_inc(miss_cnt_q);
                     base_q     <= A[WIDTH-1:LINE_LSB];
                     fcnt_q     <= {OFF_W{1'b0}};
                     state_q    <= FILL;
                  end
               end
            end
            FILL: begin
               fcnt_q <= fcnt_q + {{(OFF_W-1){1'b0}}, 1'b1};
               if (fill_last_s) begin
                  replay_q <= 1'b1;
                  state_q  <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign HIT_CNT  = hit_cnt_q;
   assign MISS_CNT = miss_cnt_q;

endmodule

// File: tb/tb_dcache.sv
// Directed, table-driven bench for dcache with a small word-addressed memory model.
module tb_dcache;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [31:0] A, WD, RD, MEM_A, MEM_WD, MEM_RD, HIT_CNT, MISS_CNT;
   logic        RE, WE, STALL, MEM_WE;

   always #5 CLK = ~CLK;

   dcache #(.WIDTH(32), .SETS(16), .CNT_W(32)) dut (
      .CLK(CLK), .RST_N(RST_N), .A(A), .WD(WD), .RE(RE), .WE(WE),
      .RD(RD), .STALL(STALL), .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_WE(MEM_WE),
      .MEM_RD(MEM_RD), .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT)
   );

   // ---------------- memory model ----------------
   logic [31:0] mem [1024];
   bit          mem_ready = 1'b0;

   function automatic int maddr(input logic [31:0] a);
      return int'({a[17:16], a[9:2]});
   endfunction

   function automatic logic [31:0] pat(input int i);
      case (i)
         256:     return 32'h1111_1111;   // 0x10000
         257:     return 32'h2222_2222;   // 0x10004
         258:     return 32'h3333_3333;   // 0x10008
         259:     return 32'h4444_4444;   // 0x1000C
         default: return 32'hC0DE_0000 + 32'(i);
      endcase
   endfunction

   always @(posedge CLK) begin
      if (!mem_ready) begin
         for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
         mem_ready <= 1'b1;
      end else if (MEM_WE) begin
         mem[maddr(MEM_A)] <= MEM_WD;
      end
   end

   assign MEM_RD = mem[maddr(MEM_A)];

   // ---------------- checking ----------------
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] wd;
      logic        re;
      logic        we;
      logic        st;
      logic [31:0] rd;
      logic        mwe;
      logic [31:0] ma;
      logic [31:0] hc;
      logic [31:0] mc;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic [31:0] a, input logic [31:0] wd, input logic re,
                               input logic we, input logic st, input logic [31:0] rd,
                               input logic mwe, input logic [31:0] ma,
                               input logic [31:0] hc, input logic [31:0] mc);
      vec_t v;
      v.a = a; v.wd = wd; v.re = re; v.we = we; v.st = st; v.rd = rd;
      v.mwe = mwe; v.ma = ma; v.hc = hc; v.mc = mc;
      vq.push_back(v);
   endfunction

   // Load miss: miss cycle, four refill beats, then the uncounted replay hit.
   function automatic void add_miss(input logic [31:0] a, input logic [31:0] rd,
                                    input logic [31:0] hc, input logic [31:0] mc);
      logic [31:0] base;
      base = {a[31:4], 4'h0};
      add(a, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, a, hc, mc);
      for (int k = 0; k < 4; k++)
         add(a, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, base + 32'(4 * k), hc, mc + 32'd1);
      add(a, 32'h0, 1'b1, 1'b0, 1'b0, rd, 1'b0, a, hc, mc + 32'd1);
   endfunction

   int st_cycles;

   initial begin
      RST_N = 1'b0; A = 32'h0; WD = 32'h0; RE = 1'b0; WE = 1'b0;

      // cold load, same-line hit, store hit, store+load (store wins)
      add_miss(32'h0001_0000, 32'h1111_1111, 32'd0, 32'd0);
      add(32'h0001_000C, 32'h0,         1'b1, 1'b0, 1'b0, 32'h4444_4444, 1'b0, 32'h0001_000C, 32'd0, 32'd1);
      add(32'h0001_0008, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0001_0008, 32'd1, 32'd1);
      add(32'h0001_0008, 32'h0,         1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0001_0008, 32'd1, 32'd1);
      add(32'h0001_000C, 32'h55AA_55AA, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0001_000C, 32'd2, 32'd1);
      add(32'h0001_000C, 32'h0,         1'b1, 1'b0, 1'b0, 32'h55AA_55AA, 1'b0, 32'h0001_000C, 32'd2, 32'd1);
      // conflict eviction and re-miss of the evicted line
      add_miss(32'h0001_0100, 32'hC0DE_0140, 32'd3, 32'd1);
      add_miss(32'h0001_0000, 32'h1111_1111, 32'd3, 32'd2);
      // store miss: no allocation, following load misses
      add(32'h0002_0000, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0002_0000, 32'd3, 32'd3);
      add_miss(32'h0002_0000, 32'h1234_5678, 32'd3, 32'd3);
      // idle cycle
      add(32'h0001_0004, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0001_0004, 32'd3, 32'd4);

      repeat (3) @(negedge CLK);
      #1;
      chk("reset stall", {31'b0, STALL}, 32'd0);
      chk("reset rd", RD, 32'h0);
      chk("reset hit_cnt", HIT_CNT, 32'd0);
      chk("reset miss_cnt", MISS_CNT, 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge CLK);
         A = vq[i].a; WD = vq[i].wd; RE = vq[i].re; WE = vq[i].we;
         #1;
         chk($sformatf("v%0d stall", i),    {31'b0, STALL},  {31'b0, vq[i].st});
         chk($sformatf("v%0d rd", i),       RD,              vq[i].rd);
         chk($sformatf("v%0d mem_we", i),   {31'b0, MEM_WE}, {31'b0, vq[i].mwe});
         chk($sformatf("v%0d mem_a", i),    MEM_A,           vq[i].ma);
         chk($sformatf("v%0d hit_cnt", i),  HIT_CNT,         vq[i].hc);
         chk($sformatf("v%0d miss_cnt", i), MISS_CNT,        vq[i].mc);
      end

      chk("mem 0x10008", mem[maddr(32'h0001_0008)], 32'hDEAD_BEEF);
      chk("mem 0x1000C", mem[maddr(32'h0001_000C)], 32'h55AA_55AA);
      chk("mem 0x20000", mem[maddr(32'h0002_0000)], 32'h1234_5678);

      // reset in the middle of a refill (fcnt=2)
      @(negedge CLK);
      A = 32'h0001_0100; WD = 32'h0; RE = 1'b1; WE = 1'b0;
      #1;
      chk("rmf miss stall", {31'b0, STALL}, 32'd1);
      repeat (3) @(negedge CLK);
      #1;
      chk("rmf fcnt2 mem_a", MEM_A, 32'h0001_0108);
      chk("rmf fcnt2 stall", {31'b0, STALL}, 32'd1);
      RST_N = 1'b0;
      #1;
      chk("rst mem_a", MEM_A, 32'h0001_0100);
      chk("rst load stall", {31'b0, STALL}, 32'd1);
      chk("rst mem_we", {31'b0, MEM_WE}, 32'd0);
      chk("rst rd", RD, 32'h0);
      chk("rst hit_cnt", HIT_CNT, 32'd0);
      chk("rst miss_cnt", MISS_CNT, 32'd0);
      RE = 1'b0;
      #1;
      chk("rst idle stall", {31'b0, STALL}, 32'd0);
      WE = 1'b1;
      #1;
      chk("rst store mem_we", {31'b0, MEM_WE}, 32'd1);
      chk("rst store stall", {31'b0, STALL}, 32'd0);
      WE = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      A = 32'h0002_0000; RE = 1'b1;
      #1;
      st_cycles = 0;
      while (STALL === 1'b1 && st_cycles < 20) begin
         st_cycles++;
         @(negedge CLK);
         #1;
      end
      chk("post-reset stall cycles", 32'(st_cycles), 32'd5);
      chk("post-reset rd", RD, 32'h1234_5678);
      chk("post-reset miss_cnt", MISS_CNT, 32'd1);
      chk("post-reset hit_cnt", HIT_CNT, 32'd0);
      @(negedge CLK);
      RE = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-through, no-write-allocate data cache between the execute/memory stage and the byte-addressed data memory. Loads that hit return data combinationally in the same cycle. Load misses stall the pipeline while a 4-word line is refilled, one word per cycle, from the memory's combinational read port. Stores are forwarded to memory unchanged and also update the cached copy on a hit.

## Interface
- `WIDTH`, 32: address and data width.
- `SETS`, 16: number of lines (power of two).
- `CNT_W`, 32: width of the performance counters.

- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `A` in WIDTH: CPU byte address, word aligned (`A[1:0]` ignored).
- `WD` in WIDTH: CPU store data.
- `RE` in 1: load request.
- `WE` in 1: store request.
- `RD` out WIDTH: load data.
- `STALL` out 1: pipeline must hold `A`/`RE`/`WE`/`WD` stable.
- `MEM_A` out WIDTH: memory address.
- `MEM_WD` out WIDTH: memory write data.
- `MEM_WE` out 1: memory write enable.
- `MEM_RD` in WIDTH: memory combinational read data.
- `HIT_CNT` out CNT_W: number of load hits.
- `MISS_CNT` out CNT_W: number of load misses.

Decided: one clock; reset is asynchronous and active-low.

## Operation
**Address split** (SETS=16)
- Word offset = `A[3:2]`.
- Index = `A[7:4]`.
- Tag = `A[WIDTH-1:8]`.
- In general, index width = log2(SETS) and tag = the remaining upper bits.

**Storage**
- Per line: valid bit, tag, 4 data words.
- Only valid bits are reset.

**Hit**
- hit = `valid[index] && tag_q[index] == tag`.

**States:** IDLE, FILL. A 2-bit fill counter `fcnt` is used in FILL.

**IDLE**
- `MEM_A=A`, `MEM_WD=WD`, `MEM_WE=WE`.
- `WE=1`: store.
  - Memory is written at the edge. No stall.
  - On a hit, the cached word is also updated at the same edge.
  - On a miss, no allocation.
  - `RE` is ignored when `WE=1` (store has priority).
- `RE=1`, `WE=0`, hit:
  - `RD` = cached word, `STALL=0`.
  - `HIT_CNT` increments, unless the `replay` flag is set. `replay` is always cleared at this edge.
- `RE=1`, `WE=0`, miss:
  - `STALL=1`, `MISS_CNT` increments.
  - Latch the line base `{tag, index, 4'b0}`; `fcnt←0`; go to FILL.
- Otherwise `RD=0`, `STALL=0`.

**FILL**
- `STALL=1`, `MEM_WE=0`.
- `MEM_A` = line base + `fcnt*4`.
- Each edge writes `MEM_RD` into word `fcnt` and increments `fcnt`.
- On the edge with `fcnt=3`: write the tag, set valid, set `replay`, go to IDLE.
- The held load then hits on the next cycle and is not counted as a hit.

**Counters** saturate at all-ones.

**Reset** (any time, including mid-FILL)
- state=IDLE, `fcnt=0`, all valid bits=0, `replay=0`, counters=0.
- Data and tag arrays keep their contents but are unused until refilled.
- While in reset: `MEM_WE=WE`, `STALL=RE&&!WE`, `RD=0`.

## Timing
- Load hit: 0-cycle latency, combinational `A`→`RD`.
- Load miss:
  - `STALL` is high in the miss cycle plus 4 FILL cycles, i.e. 5 cycles.
  - Data is valid in the 6th cycle, with `STALL=0`.
- Store: 0 stall; memory and cache are updated at the same rising edge.
- `STALL` is combinational from state, `A`, `RE`, `WE` and the tag compare. The CPU must not change its request while `STALL=1`.
- There is no simultaneous store/refill hazard, since the pipeline is frozen during FILL.

## Structure
- Package `dcache_pkg`:
  - state enum `{IDLE, FILL}`.
  - `LINE_WORDS=4`.
  - Functions or localparams deriving the index/tag/offset widths from `WIDTH` and `SETS`.
- Sub-module `dcache_array` holds the valid/tag/data storage:
  - Inputs: index, word-write port, line-fill tag/valid set, reset-clear.
  - Outputs: combinational read of the addressed line.
- The FSM, counters and muxing live in `dcache`.

## Test plan
- **Cold load:** reset, memory `0x10000..0x1000C` = `11111111,22222222,33333333,44444444`; `RE`, `A=0x10000`.
  - Expect `STALL=1` for 5 cycles, `MEM_A` = `0x10000`, `04`, `08`, `0C` in the FILL cycles, then `RD=0x11111111`.
  - Expect `MISS_CNT=1`, `HIT_CNT=0`.
- **Same-line hit:** load `0x1000C` next.
  - Expect `STALL=0`, `RD=0x44444444` in the same cycle, `HIT_CNT=1`.
- **Store hit:** store `0xDEADBEEF` to `0x10008`.
  - Expect `MEM_WE=1`, `MEM_A=0x10008`, no stall.
  - A following load of `0x10008` hits with `0xDEADBEEF`, and the memory word equals `0xDEADBEEF`.
- **Conflict eviction:** load `0x10100` (same index, different tag).
  - Expect a 5-cycle stall and `MISS_CNT=2`.
  - A subsequent load of `0x10000` misses again (`MISS_CNT=3`).
- **Store miss:** store `0x12345678` to `0x20000`.
  - Memory is written, no stall, no allocation.
  - A load of `0x20000` then misses and returns `0x12345678`.
- **Reset mid-fill:** assert `RST_N=0` while in FILL with `fcnt=2`.
  - Expect state IDLE, counters 0, `MEM_WE=0` with `WE=0`.
  - After release, a load of the previously cached line misses (5-cycle stall).
